cmd_issuer: RTL and testbench
=============================

CMD_ISSUER -- requirements
Module: cmd_issuer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 Parameter GAP_W, default 4, width of gap_cfg.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  upstream command valid.
REQ-006 in_ready  out  1  block can accept a command this cycle.
REQ-007 in_op_code  in  8  command opcode; legal values 1..4.
REQ-008 in_address  in  8  command address.
REQ-009 in_data  in  32  command data.
REQ-010 gap_cfg  in  GAP_W  idle cycles required between issued commands.
REQ-011 op_code  out  8  opcode to downstream register block; 0 = idle.
REQ-012 address  out  8  address to downstream block.
REQ-013 data  out  32  data to downstream block.
REQ-014 issue_strobe  out  1  high for the single cycle a command is presented.
REQ-015 reject  out  1  one-cycle pulse: an illegal opcode was discarded.
REQ-016 busy  out  1  high when FSM not IDLE or FIFO non-empty.
REQ-017 issued_count  out  16  number of commands issued since reset.

Function
REQ-018 Handshake: transfer occurs on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL equal !full, independent of in_valid.
REQ-019 Full FIFO: in_ready=0; no push-on-pop; a pop on the same edge raises in_ready on the next cycle.
REQ-020 A transfer with in_op_code outside 1..4 SHALL NOT be enqueued; reject SHALL be high for the cycle after that edge.
REQ-021 Legal transfers are enqueued in order, {op_code,address,data}; no reordering, no loss.
REQ-022 FSM states: IDLE, ISSUE, GAP; all outputs registered.
REQ-023 IDLE: op_code=0, issue_strobe=0; on edge with FIFO non-empty -> pop head, load outputs, go ISSUE.
REQ-024 ISSUE (exactly one cycle): op_code/address/data = popped command, issue_strobe=1; issued_count increments on entry; next edge -> GAP.
REQ-025 GAP: op_code=0, issue_strobe=0, address/data hold last issued values; lasts G=max(gap_cfg,1) cycles, gap_cfg sampled on ISSUE->GAP edge.
REQ-026 Minimum G of 1 is mandatory so downstream sees an opcode change between consecutive identical commands.
REQ-027 GAP end: FIFO non-empty -> pop and go ISSUE on that edge; else -> IDLE.
REQ-028 Latency: command accepted into empty FIFO at edge E with FSM IDLE appears on outputs from edge E+2 (one cycle FIFO, one cycle pop/register).
REQ-029 Steady-state throughput: one command per (1+G) cycles.
REQ-030 Simultaneous push and pop on one edge SHALL be supported when not full; occupancy unchanged.
REQ-031 issued_count wraps 0xFFFF -> 0x0000 without flag.
REQ-032 Pointer wrap-around at DEPTH SHALL be transparent to ordering.

Reset
REQ-033 While rst=1 at an edge: FIFO flushed (empty), FSM IDLE, op_code=0, address=0, data=0, issue_strobe=0, reject=0, issued_count=0, busy=0; in_ready=1 the cycle after reset release.
REQ-034 Reset asserted mid-ISSUE or mid-GAP SHALL abort the command and discard all queued entries; transfers during rst=1 are ignored.

Verification
REQ-035 Single command: gap_cfg=2, push {1,0x10,0xA5A5A5A5} at edge E -> op_code=1, address=0x10, data=0xA5A5A5A5, issue_strobe=1 for edges E+2..E+3 only; op_code=0 for next 2 cycles; issued_count=1; busy drops.
REQ-036 Back-to-back identical: push {2,0x01,0x8} twice, gap_cfg=0 -> op_code sequence 2,0,2,0 (G forced to 1); issued_count=2.
REQ-037 Full/backpressure: hold in_valid with 6 legal commands, DEPTH=4, gap_cfg=3 -> in_ready falls after 4 queued entries, rises after pops; all 6 issued in order, no duplicates.
REQ-038 Illegal opcode: push {0,..}, {5,..}, {4,0x22,0x0F} -> two reject pulses, only opcode 4 issued, data=0x0F.
REQ-039 Reset mid-operation: 3 commands queued, rst=1 during first GAP -> all outputs zero next cycle, remaining 2 never issued, issued_count=0.
REQ-040 Counter wrap: force 65536 issues -> issued_count returns to 0x0000, issuing continues normally.

Source files
------------

// File: rtl/cmd_issuer_if.sv
// Upstream command handshake between a command source and the cmd_issuer FIFO.
interface cmd_issuer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_op_code;
    logic [7:0]  in_address;
    logic [31:0] in_data;

    modport master (
        output in_valid,
        output in_op_code,
        output in_address,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_op_code,
        input  in_address,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/cmd_issuer.sv
// Queues upstream commands in a small FIFO and presents them to a downstream register
// block one at a time, with a programmable idle gap (minimum one cycle) between them.
module cmd_issuer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    cmd_issuer_if.slave      cmd,
    input  logic [GAP_W-1:0] gap_cfg,
    output logic [7:0]       op_code,
    output logic [7:0]       address,
    output logic [31:0]      data,
    output logic             issue_strobe,
    output logic             reject,
    output logic             busy,
    output logic [15:0]      issued_count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  addr;
        logic [31:0] dat;
    } cmd_t;

    cmd_t          mem_q [DEPTH];
    cmd_t          wr_cmd;
    cmd_t          head;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty, legal, accept, push, pop;

    state_e         state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]     op_code_q, op_code_d;
    logic [7:0]     address_q, address_d;
    logic [31:0]    data_q, data_d;
    logic           strobe_q, strobe_d;
    logic [15:0]    issued_count_q, issued_count_d;
    logic           reject_q;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign legal  = (cmd.in_op_code != 8'd0) && (cmd.in_op_code <= 8'd4);
    assign accept = cmd.in_valid && !full && !rst;
    assign push   = accept && legal;
    assign wr_cmd = {cmd.in_op_code, cmd.in_address, cmd.in_data};
    assign head   = mem_q[rd_ptr_q];

    assign cmd.in_ready = !full;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        state_d        = state_q;
        gap_cnt_d      = gap_cnt_q;
        op_code_d      = op_code_q;
        address_d      = address_q;
        data_d         = data_q;
        strobe_d       = 1'b0;
        issued_count_d = issued_count_q;
        pop            = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d   = StGap;
                op_code_d = 8'd0;
                // A zero gap is stretched to one so repeated identical commands stay distinct.
                gap_cnt_d = (gap_cfg == '0) ? GAP_W'(1) : gap_cfg;
            end
            StGap: begin
                if (gap_cnt_q > GAP_W'(1)) begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end else if (!empty) begin
                    pop     = 1'b1;
                    state_d = StIssue;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (pop) begin
            op_code_d      = head.op;
            address_d      = head.addr;
            data_d         = head.dat;
            strobe_d       = 1'b1;
            issued_count_d = issued_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            gap_cnt_q      <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            op_code_q      <= '0;
            address_q      <= '0;
            data_q         <= '0;
            strobe_q       <= 1'b0;
            issued_count_q <= '0;
            reject_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            gap_cnt_q      <= gap_cnt_d;
            count_q        <= count_d;
            op_code_q      <= op_code_d;
            address_q      <= address_d;
            data_q         <= data_d;
            strobe_q       <= strobe_d;
            issued_count_q <= issued_count_d;
            reject_q       <= accept && !legal;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_cmd;
        end
    end

    assign op_code      = op_code_q;
    assign address      = address_q;
    assign data         = data_q;
    assign issue_strobe = strobe_q;
    assign reject       = reject_q;
    assign busy         = (state_q != StIdle) || !empty;
    assign issued_count = issued_count_q;
endmodule

// File: tb/tb_cmd_issuer.sv
// Directed self-checking bench for cmd_issuer: reset, single issue, gaps, backpressure,
// illegal opcodes, mid-operation reset and issue counter wrap.
module tb_cmd_issuer;
    logic        clk;
    logic        rst;
    logic [3:0]  gap_cfg;
    logic [7:0]  op_code;
    logic [7:0]  address;
    logic [31:0] data;
    logic        issue_strobe;
    logic        reject;
    logic        busy;
    logic [15:0] issued_count;

    int n_chk;
    int n_fail;

    cmd_issuer_if cmd_if ();

    cmd_issuer #(
        .DEPTH(4),
        .GAP_W(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cmd_if),
        .gap_cfg     (gap_cfg),
        .op_code     (op_code),
        .address     (address),
        .data        (data),
        .issue_strobe(issue_strobe),
        .reject      (reject),
        .busy        (busy),
        .issued_count(issued_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] op, input logic [7:0] a,
                         input logic [31:0] d);
        cmd_if.in_valid   = v;
        cmd_if.in_op_code = op;
        cmd_if.in_address = a;
        cmd_if.in_data    = d;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 32'd0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        gap_cfg = 4'd1;
        rst = 1'b1;
        // Legal traffic offered while reset is held must be ignored.
        drive(1'b1, 8'd1, 8'h55, 32'h1234_5678);
        step();
        step();
        rst = 1'b0;
        cmd_if.in_valid = 1'b0;
        n_chk++;
        if ({op_code, address, data} !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got op=%0h addr=%0h data=%0h want 0/0/0",
                     op_code, address, data);
        end
        n_chk++;
        if ({issue_strobe, reject, busy} !== 3'b000 || issued_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got stb=%b rej=%b busy=%b cnt=%0d want 0/0/0/0",
                     issue_strobe, reject, busy, issued_count);
        end
        n_chk++;
        if (cmd_if.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", cmd_if.in_ready);
        end
        step();
        step();
        step();
        n_chk++;
        if (busy !== 1'b0 || issued_count !== 16'd0 || op_code !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_ignored: got busy=%b cnt=%0d op=%0d want 0/0/0",
                     busy, issued_count, op_code);
        end
    endtask

    task automatic test_single();
        apply_reset();
        gap_cfg = 4'd2;
        drive(1'b1, 8'd1, 8'h10, 32'hA5A5_A5A5);
        step();
        cmd_if.in_valid = 1'b0;
        n_chk++;
        if (issue_strobe !== 1'b0 || op_code !== 8'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_queued: got stb=%b op=%0d busy=%b want 0/0/1",
                     issue_strobe, op_code, busy);
        end
        step();
        n_chk++;
        if (op_code !== 8'd1 || address !== 8'h10 || data !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL single_cmd: got %0h/%0h/%0h want 1/10/a5a5a5a5",
                     op_code, address, data);
        end
        n_chk++;
        if (issue_strobe !== 1'b1 || issued_count !== 16'd1) begin
            n_fail++;
            $display("FAIL single_strobe: got stb=%b cnt=%0d want 1/1", issue_strobe,
                     issued_count);
        end
        step();
        n_chk++;
        if (op_code !== 8'd0 || issue_strobe !== 1'b0 || address !== 8'h10
            || data !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL single_gap1: got op=%0d stb=%b addr=%0h data=%0h want 0/0/10/a5a5a5a5",
                     op_code, issue_strobe, address, data);
        end
        step();
        n_chk++;
        if (op_code !== 8'd0 || issue_strobe !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_gap2: got op=%0d stb=%b busy=%b want 0/0/1",
                     op_code, issue_strobe, busy);
        end
        step();
        n_chk++;
        if (busy !== 1'b0 || issued_count !== 16'd1) begin
            n_fail++;
            $display("FAIL single_idle: got busy=%b cnt=%0d want 0/1", busy, issued_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want_op [4] = '{8'd2, 8'd0, 8'd2, 8'd0};
        logic       want_stb [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        apply_reset();
        gap_cfg = 4'd0;
        drive(1'b1, 8'd2, 8'h01, 32'h8);
        step();
        step();
        cmd_if.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (op_code !== want_op[i] || issue_strobe !== want_stb[i]) begin
                n_fail++;
                $display("FAIL b2b_seq[%0d]: got op=%0d stb=%b want %0d/%b", i, op_code,
                         issue_strobe, want_op[i], want_stb[i]);
            end
            step();
        end
        n_chk++;
        if (issued_count !== 16'd2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_count: got cnt=%0d busy=%b want 2/0", issued_count, busy);
        end
    endtask

    task automatic test_full();
        int k = 0;
        int n_iss = 0;
        int iss_cyc [6];
        logic rdy;
        logic drove;
        apply_reset();
        gap_cfg = 4'd3;
        for (int cyc = 0; cyc < 120; cyc++) begin
            drove = (k < 6);
            if (drove) begin
                drive(1'b1, 8'((k % 4) + 1), 8'(8'h30 + k), 32'h1000_0000 + 32'(k));
            end else begin
                cmd_if.in_valid = 1'b0;
            end
            rdy = cmd_if.in_ready;
            step();
            if (drove && rdy) k++;
            if (cyc == 4) begin
                n_chk++;
                if (cmd_if.in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_ready_low: got %b want 0", cmd_if.in_ready);
                end
            end
            if (cyc == 5) begin
                n_chk++;
                if (cmd_if.in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL full_ready_high: got %b want 1", cmd_if.in_ready);
                end
            end
            if (issue_strobe === 1'b1) begin
                n_chk++;
                if (n_iss >= 6) begin
                    n_fail++;
                    $display("FAIL full_extra_issue: got issue #%0d want at most 6", n_iss + 1);
                end else if (op_code !== 8'((n_iss % 4) + 1) || address !== 8'(8'h30 + n_iss)
                             || data !== 32'h1000_0000 + 32'(n_iss)) begin
                    n_fail++;
                    $display("FAIL full_order[%0d]: got %0h/%0h/%0h want %0h/%0h/%0h", n_iss,
                             op_code, address, data, (n_iss % 4) + 1, 8'h30 + n_iss,
                             32'h1000_0000 + 32'(n_iss));
                end
                if (n_iss < 6) iss_cyc[n_iss] = cyc;
                n_iss++;
            end
            if (k == 6 && n_iss >= 6 && busy === 1'b0) break;
        end
        n_chk++;
        if (n_iss != 6 || issued_count !== 16'd6) begin
            n_fail++;
            $display("FAIL full_issue_count: got seen=%0d cnt=%0d want 6/6", n_iss, issued_count);
        end
        n_chk++;
        if (n_iss >= 2 && iss_cyc[1] - iss_cyc[0] != 4) begin
            n_fail++;
            $display("FAIL full_spacing: got %0d cycles want 4", iss_cyc[1] - iss_cyc[0]);
        end
    endtask

    task automatic test_illegal();
        logic [7:0]  ops [3]   = '{8'd0, 8'd5, 8'd4};
        logic [7:0]  addrs [3] = '{8'h20, 8'h21, 8'h22};
        logic [31:0] dats [3]  = '{32'h1, 32'h2, 32'h0F};
        int n_rej = 0;
        int n_iss = 0;
        apply_reset();
        gap_cfg = 4'd1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc < 3) drive(1'b1, ops[cyc], addrs[cyc], dats[cyc]);
            else cmd_if.in_valid = 1'b0;
            step();
            if (reject === 1'b1) n_rej++;
            if (cyc == 0) begin
                n_chk++;
                if (reject !== 1'b1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL illegal_first: got rej=%b busy=%b want 1/0", reject, busy);
                end
            end
            if (cyc == 2) begin
                n_chk++;
                if (reject !== 1'b0) begin
                    n_fail++;
                    $display("FAIL illegal_legal_norej: got %b want 0", reject);
                end
            end
            if (issue_strobe === 1'b1) begin
                n_iss++;
                n_chk++;
                if (op_code !== 8'd4 || address !== 8'h22 || data !== 32'h0F) begin
                    n_fail++;
                    $display("FAIL illegal_issue: got %0h/%0h/%0h want 4/22/f", op_code,
                             address, data);
                end
            end
        end
        n_chk++;
        if (n_rej != 2 || n_iss != 1 || issued_count !== 16'd1) begin
            n_fail++;
            $display("FAIL illegal_counts: got rej=%0d iss=%0d cnt=%0d want 2/1/1", n_rej,
                     n_iss, issued_count);
        end
    endtask

    task automatic test_reset_mid();
        int n_iss = 0;
        apply_reset();
        gap_cfg = 4'd3;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'd3, 8'(8'h50 + i), 32'hBEEF_0000 + 32'(i));
            step();
        end
        cmd_if.in_valid = 1'b0;
        // First command issued on the second edge, so the third edge lands in GAP.
        n_chk++;
        if (op_code !== 8'd0 || busy !== 1'b1 || issued_count !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_pre: got op=%0d busy=%b cnt=%0d want 0/1/1", op_code, busy,
                     issued_count);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_chk++;
        if ({op_code, address, data} !== 48'd0 || issue_strobe !== 1'b0
            || issued_count !== 16'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got op=%0h addr=%0h data=%0h stb=%b cnt=%0d busy=%b want zeros",
                     op_code, address, data, issue_strobe, issued_count, busy);
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            step();
            if (issue_strobe === 1'b1) n_iss++;
        end
        n_chk++;
        if (n_iss != 0 || issued_count !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_flushed: got iss=%0d cnt=%0d want 0/0", n_iss, issued_count);
        end
    endtask

    task automatic test_wrap();
        int k = 0;
        int n_iss = 0;
        logic [15:0] want_cnt;
        apply_reset();
        gap_cfg = 4'd0;
        // Preload the counter rather than spending 65534 issues getting near the wrap.
        dut.issued_count_q = 16'hFFFE;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (k < 4) drive(1'b1, 8'd3, 8'(8'h40 + k), 32'hC0DE_0000 + 32'(k));
            else cmd_if.in_valid = 1'b0;
            step();
            if (k < 4) k++;
            if (issue_strobe === 1'b1) begin
                want_cnt = 16'hFFFE + 16'(n_iss + 1);
                n_chk++;
                if (issued_count !== want_cnt || address !== 8'(8'h40 + n_iss)
                    || data !== 32'hC0DE_0000 + 32'(n_iss)) begin
                    n_fail++;
                    $display("FAIL wrap[%0d]: got cnt=%0h addr=%0h data=%0h want %0h/%0h/%0h",
                             n_iss, issued_count, address, data, want_cnt, 8'h40 + n_iss,
                             32'hC0DE_0000 + 32'(n_iss));
                end
                n_iss++;
            end
            if (k == 4 && n_iss >= 4 && busy === 1'b0) break;
        end
        n_chk++;
        if (n_iss != 4 || issued_count !== 16'h0002) begin
            n_fail++;
            $display("FAIL wrap_final: got iss=%0d cnt=%0h want 4/0002", n_iss, issued_count);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        gap_cfg = 4'd0;
        drive(1'b0, 8'd0, 8'd0, 32'd0);
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_illegal();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
